// File: rtl/fp_pkg.sv
// Single-precision field layout shared by the scheduler and its multiplier core.
package fp_pkg;

  localparam int unsigned EXP_BIAS = 127;
  localparam int unsigned EXP_W    = 8;
  localparam int unsigned MAN_W    = 23;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } fp32_t;

endpackage

// File: rtl/fp_mul_core.sv
// Combinational single-precision multiply: truncating, one-step normalisation,
// zero operands force +0, no denormal/Inf/NaN/range handling.
module fp_mul_core
  import fp_pkg::*;
(
  input  fp32_t a_i,
  input  fp32_t b_i,
  output fp32_t p_o
);

  localparam int unsigned PW = 2 * (MAN_W + 1);

  logic          a_zero;
  logic          b_zero;
  logic [PW-1:0] man_prod;
  logic [EXP_W:0] exp_sum;

  assign a_zero   = (a_i.exp == '0) && (a_i.man == '0);
  assign b_zero   = (b_i.exp == '0) && (b_i.man == '0);
  assign man_prod = PW'({1'b1, a_i.man}) * PW'({1'b1, b_i.man});
  // Nine bits wide so the bias subtraction wraps predictably before truncation.
  assign exp_sum  = {1'b0, a_i.exp} + {1'b0, b_i.exp} - (EXP_W + 1)'(EXP_BIAS);

  always_comb begin
    p_o = '0;
    if (!(a_zero || b_zero)) begin
      p_o.sign = a_i.sign ^ b_i.sign;
      if (man_prod[PW-1]) begin
        p_o.exp = exp_sum[EXP_W-1:0] + EXP_W'(1);
        p_o.man = man_prod[PW-2 -: MAN_W];
      end else begin
        p_o.exp = exp_sum[EXP_W-1:0];
        p_o.man = man_prod[PW-3 -: MAN_W];
      end
    end
  end

endmodule

// File: rtl/fp_mul_sched.sv
// Round-robin scheduler sharing one fp32 multiplier among N_REQ requesters;
// two-stage pipeline (operand register, product register) with response backpressure.
module fp_mul_sched
  import fp_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = $clog2(N_REQ)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req_valid,
  input  logic [32*N_REQ-1:0] req_a,
  input  logic [32*N_REQ-1:0] req_b,
  output logic [N_REQ-1:0]    req_ready,
  output logic                rsp_valid,
  output logic [ID_W-1:0]     rsp_id,
  output logic [31:0]         rsp_result,
  input  logic                rsp_ready,
  output logic [31:0]         op_count
);

  logic [ID_W-1:0]  last_grant_q, last_grant_d;
  logic             s1_valid_q, s1_valid_d;
  fp32_t            s1_a_q, s1_a_d;
  fp32_t            s1_b_q, s1_b_d;
  logic [ID_W-1:0]  s1_id_q, s1_id_d;
  logic             s2_valid_q, s2_valid_d;
  logic [31:0]      s2_result_q, s2_result_d;
  logic [ID_W-1:0]  s2_id_q, s2_id_d;
  logic [31:0]      op_count_q, op_count_d;

  logic             s2_adv;
  logic             s1_ready;
  logic             grant_found;
  logic [ID_W-1:0]  grant_id;
  logic [ID_W-1:0]  scan_idx;
  logic [N_REQ-1:0] grant_oh;
  logic             accept;
  fp32_t            a_sel;
  fp32_t            b_sel;
  fp32_t            s1_prod;
  logic             rsp_fire;

  assign s2_adv   = !s2_valid_q || rsp_ready;
  assign s1_ready = !s1_valid_q || s2_adv;
  assign rsp_fire = s2_valid_q && rsp_ready;

  // Scan starts one past the last granted requester.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    scan_idx    = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      scan_idx = ID_W'((32'(last_grant_q) + k) % N_REQ);
      if (!grant_found && req_valid[scan_idx]) begin
        grant_found = 1'b1;
        grant_id    = scan_idx;
      end
    end
  end

  always_comb begin
    grant_oh = '0;
    a_sel    = '0;
    b_sel    = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      grant_oh[i] = grant_found && (grant_id == ID_W'(i));
      if (grant_oh[i]) begin
        a_sel = req_a[32*i +: 32];
        b_sel = req_b[32*i +: 32];
      end
    end
  end

  assign accept    = s1_ready && grant_found;
  assign req_ready = s1_ready ? grant_oh : '0;

  fp_mul_core u_core (
    .a_i (s1_a_q),
    .b_i (s1_b_q),
    .p_o (s1_prod)
  );

  always_comb begin
    last_grant_d = last_grant_q;
    s1_valid_d   = s1_valid_q;
    s1_a_d       = s1_a_q;
    s1_b_d       = s1_b_q;
    s1_id_d      = s1_id_q;
    s2_valid_d   = s2_valid_q;
    s2_result_d  = s2_result_q;
    s2_id_d      = s2_id_q;
    op_count_d   = op_count_q + (rsp_fire ? 32'd1 : 32'd0);

    if (accept) begin
      last_grant_d = grant_id;
      s1_valid_d   = 1'b1;
      s1_a_d       = a_sel;
      s1_b_d       = b_sel;
      s1_id_d      = grant_id;
    end else if (s2_adv) begin
      s1_valid_d = 1'b0;
    end

    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_result_d = s1_prod;
        s2_id_d     = s1_id_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= ID_W'(N_REQ - 1);
      s1_valid_q   <= 1'b0;
      s1_a_q       <= '0;
      s1_b_q       <= '0;
      s1_id_q      <= '0;
      s2_valid_q   <= 1'b0;
      s2_result_q  <= '0;
      s2_id_q      <= '0;
      op_count_q   <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      s1_valid_q   <= s1_valid_d;
      s1_a_q       <= s1_a_d;
      s1_b_q       <= s1_b_d;
      s1_id_q      <= s1_id_d;
      s2_valid_q   <= s2_valid_d;
      s2_result_q  <= s2_result_d;
      s2_id_q      <= s2_id_d;
      op_count_q   <= op_count_d;
    end
  end

  assign rsp_valid  = s2_valid_q;
  assign rsp_id     = s2_id_q;
  assign rsp_result = s2_result_q;
  assign op_count   = op_count_q;

endmodule

// File: tb/tb_fp_mul_sched.sv
// Directed bench for fp_mul_sched with a reference occupancy model and an in-order
// scoreboard of expected {id, product} pairs.
module tb_fp_mul_sched;

  localparam int unsigned N = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_valid;
  logic [32*N-1:0] req_a;
  logic [32*N-1:0] req_b;
  logic [N-1:0]  req_ready;
  logic          rsp_valid;
  logic [1:0]    rsp_id;
  logic [31:0]   rsp_result;
  logic          rsp_ready;
  logic [31:0]   op_count;

  fp_mul_sched #(.N_REQ(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_ready  (rsp_ready),
    .op_count   (op_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  id;
    logic [31:0] p;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] op_a[N];
  logic [31:0] op_b[N];
  logic [31:0] op_p[N];
  logic        m1v, m2v;
  int          m_last;
  logic [31:0] m_count;
  int          n_vec = 0;
  int          n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    assert (got === want) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, want);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= int'(N); k++) begin
      int idx;
      idx = (last + k) % int'(N);
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] p);
    op_a[i] = a;
    op_b[i] = b;
    op_p[i] = p;
  endtask

  task automatic model_reset();
    m1v     = 1'b0;
    m2v     = 1'b0;
    m_last  = int'(N) - 1;
    m_count = '0;
    sbq.delete();
  endtask

  // One cycle: drive, check against the model just before the edge, advance the model.
  task automatic step(input logic [N-1:0] v, input logic rr);
    int         g;
    logic       adv, s1rdy, n1, n2;
    logic [N-1:0] er;
    exp_t       h;
    req_valid = v;
    rsp_ready = rr;
    for (int i = 0; i < int'(N); i++) begin
      req_a[32*i +: 32] = op_a[i];
      req_b[32*i +: 32] = op_b[i];
    end
    #1;
    adv   = !m2v || rr;
    s1rdy = !m1v || adv;
    g     = s1rdy ? rr_pick(v, m_last) : -1;
    er    = (g >= 0) ? N'(1 << g) : '0;
    chk("req_ready", 32'(req_ready), 32'(er));
    chk("rsp_valid", 32'(rsp_valid), 32'(m2v));
    chk("op_count", op_count, m_count);
    if (m2v) begin
      if (sbq.size() == 0) begin
        chk("scoreboard_underflow", 32'(sbq.size()), 32'd1);
      end else begin
        h = sbq[0];
        chk("rsp_id", 32'(rsp_id), 32'(h.id));
        chk("rsp_result", rsp_result, h.p);
        if (rr) begin
          void'(sbq.pop_front());
          m_count = m_count + 32'd1;
        end
      end
    end
    if (g >= 0) begin
      sbq.push_back({2'(g), op_p[g]});
      m_last = g;
    end
    n2  = adv ? m1v : m2v;
    n1  = (g >= 0) ? 1'b1 : (adv ? 1'b0 : m1v);
    m1v = n1;
    m2v = n2;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_op_count", op_count, 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_rsp_result", rsp_result, 32'd0);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    for (int i = 0; i < int'(N); i++) set_op(i, 32'h0, 32'h0, 32'h0);
    @(posedge clk);
    #1;
    do_reset();

    // Single op from requester 2: 2.0 * 3.0
    set_op(2, 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000);
    step(4'b0100, 1'b1);
    for (int i = 0; i < 3; i++) step(4'b0000, 1'b1);
    chk("single_op_count", op_count, 32'd1);

    // Normalisation, sign and zero operands via requesters 1 and 3
    set_op(1, 32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000);
    step(4'b0010, 1'b1);
    set_op(1, 32'hC000_0000, 32'h4040_0000, 32'hC0C0_0000);
    step(4'b0010, 1'b1);
    set_op(3, 32'h0000_0000, 32'hC040_0000, 32'h0000_0000);
    step(4'b1000, 1'b1);
    set_op(3, 32'h8000_0000, 32'h4040_0000, 32'h0000_0000);
    step(4'b1000, 1'b1);
    set_op(3, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000);
    step(4'b1000, 1'b1);
    for (int i = 0; i < 3; i++) step(4'b0000, 1'b1);
    chk("directed_op_count", op_count, 32'd6);

    // Fairness: all valid, full throughput
    set_op(0, 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000);
    set_op(1, 32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000);
    set_op(2, 32'hC000_0000, 32'h4040_0000, 32'hC0C0_0000);
    set_op(3, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000);
    do_reset();
    for (int i = 0; i < 8; i++) step(4'b1111, 1'b1);
    for (int i = 0; i < 3; i++) step(4'b0000, 1'b1);
    chk("fair_op_count", op_count, 32'd8);

    // Backpressure: stall 5 cycles, then drain
    for (int i = 0; i < 5; i++) step(4'b1111, 1'b0);
    chk("bp_occupancy", 32'(sbq.size()), 32'd2);
    for (int i = 0; i < 3; i++) step(4'b0000, 1'b1);
    chk("bp_op_count", op_count, 32'd10);

    // Reset with both stages full; first grant afterwards goes to requester 0
    for (int i = 0; i < 3; i++) step(4'b1111, 1'b0);
    do_reset();
    step(4'b1111, 1'b1);
    for (int i = 0; i < 3; i++) step(4'b0000, 1'b1);
    chk("post_rst_op_count", op_count, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
